// File: rtl/ia_pkt_pkg.sv
// Shared definitions for the packet assembler: FSM state encoding,
// error codes reported on err_code and the default header byte.
package ia_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Mod-256 running checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/ia_pkt_timeout.sv
// Inter-byte idle counter. Counts cycles while enabled and no byte arrives;
// expire_o is a combinational pulse on the last idle cycle so the owner can
// register the error on the following edge. A byte on that same cycle
// (clear_i) suppresses the pulse. TIMEOUT_CYC = 0 disables the counter.
module ia_pkt_timeout #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          hit;

            assign hit      = enable_i && !clear_i && (cnt_q == LAST);
            assign expire_o = hit;

            // Next count: restart on any byte, when idle, or after firing.
            always_comb begin
                cnt_d = cnt_q + 1'b1;
                if (!enable_i || clear_i || hit) begin
                    cnt_d = '0;
                end
            end

            // Counter register.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ia_pkt.sv
// Packet assembler: hunts for an optional sync byte, forwards PKT_LEN payload
// bytes as indexed one-cycle update strobes, optionally verifies a trailing
// mod-256 checksum and aborts a packet when the line goes quiet too long.
module ia_pkt
    import ia_pkt_pkg::*;
#(
    parameter int unsigned PKT_LEN     = 55,
    parameter int unsigned IDX_W       = $clog2(PKT_LEN),
    parameter bit          SYNC_EN     = 1'b1,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter bit          CSUM_EN     = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             update_reg_o,
    output logic [7:0]       read_data_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             pc_ready_o,
    output logic             pkt_err_o,
    output logic [1:0]       err_code_o,
    output logic             busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] base_cnt;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       base_acc;
    logic             upd_q, upd_d;
    logic             rdy_q, rdy_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [1:0]       ecode_q, ecode_d;
    logic             take;
    logic             tmo_en;
    logic             expire;

    assign tmo_en = (state_q != ST_IDLE);

    ia_pkt_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .enable_i(tmo_en),
        .clear_i (byte_valid_i),
        .expire_o(expire)
    );

    // Next-state and output decode. Without a sync header, a byte seen in
    // IDLE is payload index 0, so payload handling starts from a zeroed
    // counter/accumulator whenever the FSM is idle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rdata_d  = rdata_q;
        idx_d    = idx_q;
        upd_d    = 1'b0;
        pend_d   = 1'b0;
        rdy_d    = pend_q;
        err_d    = 1'b0;
        ecode_d  = ecode_q;
        take     = 1'b0;
        base_cnt = (state_q == ST_IDLE) ? '0 : cnt_q;
        base_acc = (state_q == ST_IDLE) ? 8'h00 : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (byte_valid_i) begin
                    if (!SYNC_EN) begin
                        take = 1'b1;
                    end else if (byte_data_i == SYNC_BYTE) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                        acc_d   = 8'h00;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid_i) begin
                    take = 1'b1;
                end
            end
            ST_CHECK: begin
                if (byte_valid_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (byte_data_i == acc_q) begin
                        rdy_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            rdata_d = byte_data_i;
            idx_d   = base_cnt;
            upd_d   = 1'b1;
            acc_d   = csum_add(base_acc, byte_data_i);
            if (base_cnt == LAST_IDX) begin
                cnt_d = '0;
                if (CSUM_EN) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b1;
                end
            end else begin
                cnt_d   = base_cnt + 1'b1;
                state_d = ST_PAYLOAD;
            end
        end

        // expire only fires in a packet state on a cycle with no byte.
        if (expire) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            ecode_d = ERR_TIMEOUT;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any partial packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= 8'h00;
            rdata_q <= 8'h00;
            idx_q   <= '0;
            upd_q   <= 1'b0;
            rdy_q   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            upd_q   <= upd_d;
            rdy_q   <= rdy_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ecode_q <= ecode_d;
        end
    end

    assign update_reg_o = upd_q;
    assign read_data_o  = rdata_q;
    assign idx_o        = idx_q;
    assign pc_ready_o   = rdy_q;
    assign pkt_err_o    = err_q;
    assign err_code_o   = ecode_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ia_pkt.sv
// Bench for ia_pkt: four differently configured instances share one byte
// stream. A packet-level model turns the timed byte list into the expected
// strobe events (edge number, kind, idx, data) for each configuration, and the
// observed strobes are matched against that list.
module tb_ia_pkt;

    typedef struct {
        int d;
        int e;
        int k;
        int ix;
        int dat;
    } ev_t;

    localparam int EV_UPD = 0;
    localparam int EV_RDY = 1;
    localparam int EV_ERR = 2;
    localparam int NDUT   = 4;

    int cfg_len  [NDUT] = '{4, 4, 55, 2};
    int cfg_sync [NDUT] = '{1, 1, 0, 0};
    int cfg_csum [NDUT] = '{1, 0, 0, 1};
    int cfg_tmo  [NDUT] = '{20, 20, 50000, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    logic       upd_a  [NDUT];
    logic [7:0] rd_a   [NDUT];
    logic [7:0] idx_a  [NDUT];
    logic       pcr_a  [NDUT];
    logic       err_a  [NDUT];
    logic [1:0] ec_a   [NDUT];
    logic       busy_a [NDUT];
    logic [1:0] idx0, idx1;
    logic [5:0] idx2;
    logic [0:0] idx3;

    assign idx_a[0] = 8'(idx0);
    assign idx_a[1] = 8'(idx1);
    assign idx_a[2] = 8'(idx2);
    assign idx_a[3] = 8'(idx3);

    ia_pkt #(.PKT_LEN(4), .SYNC_EN(1'b1), .CSUM_EN(1'b1), .TIMEOUT_CYC(20)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .update_reg_o(upd_a[0]), .read_data_o(rd_a[0]), .idx_o(idx0), .pc_ready_o(pcr_a[0]),
        .pkt_err_o(err_a[0]), .err_code_o(ec_a[0]), .busy_o(busy_a[0]));

    ia_pkt #(.PKT_LEN(4), .SYNC_EN(1'b1), .CSUM_EN(1'b0), .TIMEOUT_CYC(20)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .update_reg_o(upd_a[1]), .read_data_o(rd_a[1]), .idx_o(idx1), .pc_ready_o(pcr_a[1]),
        .pkt_err_o(err_a[1]), .err_code_o(ec_a[1]), .busy_o(busy_a[1]));

    ia_pkt #(.PKT_LEN(55), .SYNC_EN(1'b0), .CSUM_EN(1'b0), .TIMEOUT_CYC(50000)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .update_reg_o(upd_a[2]), .read_data_o(rd_a[2]), .idx_o(idx2), .pc_ready_o(pcr_a[2]),
        .pkt_err_o(err_a[2]), .err_code_o(ec_a[2]), .busy_o(busy_a[2]));

    ia_pkt #(.PKT_LEN(2), .SYNC_EN(1'b0), .CSUM_EN(1'b1), .TIMEOUT_CYC(0)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .update_reg_o(upd_a[3]), .read_data_o(rd_a[3]), .idx_o(idx3), .pc_ready_o(pcr_a[3]),
        .pkt_err_o(err_a[3]), .err_code_o(ec_a[3]), .busy_o(busy_a[3]));

    always #5 clk = ~clk;

    int         edge_n = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         s_edge [$];
    logic [7:0] s_data [$];
    ev_t        obs_q [$];
    ev_t        exp_q [$];
    logic [1:0] exp_ec [NDUT];
    logic       exp_busy [NDUT];

    // Record every strobe just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        edge_n = edge_n + 1;
        for (int d = 0; d < NDUT; d++) begin
            if (upd_a[d] === 1'b1) obs_q.push_back('{d, edge_n, EV_UPD, int'(idx_a[d]), int'(rd_a[d])});
            if (pcr_a[d] === 1'b1) obs_q.push_back('{d, edge_n, EV_RDY, 0, 0});
            if (err_a[d] === 1'b1) obs_q.push_back('{d, edge_n, EV_ERR, 0, 0});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic seg_begin();
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_edge.delete();
        s_data.delete();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        s_edge.push_back(edge_n + 1);
        s_data.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    // Packet-level reference: walk the timed byte list per configuration.
    task automatic run_model(input int end_e);
        for (int d = 0; d < NDUT; d++) begin
            bit in_pkt = 0;
            int pos = 0, sum = 0, last = 0, ec = 0;
            for (int i = 0; i < s_edge.size(); i++) begin
                int t = s_edge[i];
                int b = int'(s_data[i]);
                if (t > end_e) break;
                if (in_pkt && cfg_tmo[d] != 0 && (t - last) > cfg_tmo[d]) begin
                    exp_q.push_back('{d, last + cfg_tmo[d], EV_ERR, 0, 0});
                    ec = 2;
                    in_pkt = 0;
                end
                last = t;
                if (!in_pkt) begin
                    pos = 0;
                    sum = 0;
                    if (cfg_sync[d] != 0) begin
                        if (b == 8'hA5) in_pkt = 1;
                        continue;
                    end
                    in_pkt = 1;
                end
                if (pos < cfg_len[d]) begin
                    exp_q.push_back('{d, t, EV_UPD, pos, b});
                    sum = (sum + b) % 256;
                    pos++;
                    if (pos == cfg_len[d] && cfg_csum[d] == 0) begin
                        if (t + 1 <= end_e) exp_q.push_back('{d, t + 1, EV_RDY, 0, 0});
                        in_pkt = 0;
                    end
                end else begin
                    if (b == sum) exp_q.push_back('{d, t, EV_RDY, 0, 0});
                    else begin
                        exp_q.push_back('{d, t, EV_ERR, 0, 0});
                        ec = 1;
                    end
                    in_pkt = 0;
                end
            end
            if (in_pkt && cfg_tmo[d] != 0 && last + cfg_tmo[d] <= end_e) begin
                exp_q.push_back('{d, last + cfg_tmo[d], EV_ERR, 0, 0});
                ec = 2;
                in_pkt = 0;
            end
            exp_ec[d]   = 2'(ec);
            exp_busy[d] = in_pkt;
        end
    endtask

    function automatic bit ev_eq(input ev_t a, input ev_t b);
        return a.d == b.d && a.e == b.e && a.k == b.k && a.ix == b.ix && a.dat == b.dat;
    endfunction

    // Build the expected list and pair it off against what was observed.
    task automatic seg_eval(output int miss, output int extra);
        int hit;
        run_model(edge_n);
        miss = 0;
        foreach (exp_q[i]) begin
            hit = -1;
            foreach (obs_q[j]) if (hit < 0 && ev_eq(obs_q[j], exp_q[i])) hit = j;
            if (hit >= 0) obs_q.delete(hit);
            else begin
                miss++;
                $display("  missing dut%0d edge %0d kind %0d idx %0d data %02h",
                         exp_q[i].d, exp_q[i].e, exp_q[i].k, exp_q[i].ix, exp_q[i].dat);
            end
        end
        extra = obs_q.size();
        foreach (obs_q[j])
            $display("  unexpected dut%0d edge %0d kind %0d idx %0d data %02h",
                     obs_q[j].d, obs_q[j].e, obs_q[j].k, obs_q[j].ix, obs_q[j].dat);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({upd_a[d], rd_a[d], idx_a[d], pcr_a[d], err_a[d], ec_a[d], busy_a[d]} !== 22'd0)
                $display("FAIL reset_outputs dut%0d got upd=%b rd=%02h idx=%0d rdy=%b err=%b ec=%0d busy=%b want all 0",
                         d, upd_a[d], rd_a[d], idx_a[d], pcr_a[d], err_a[d], ec_a[d], busy_a[d]);
            else n_pass++;
        end
    endtask

    task automatic test_sync_hunt();
        int miss, extra;
        logic [7:0] seq [6] = '{8'h11, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        seg_begin();
        foreach (seq[i]) send(seq[i], 0);
        idle(8);
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL sync_hunt events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL sync_hunt events_unexpected got %0d want 0", extra); else n_pass++;
        for (int d = 0; d < NDUT; d++) begin
            n_checks += 2;
            if (ec_a[d] !== exp_ec[d]) $display("FAIL sync_hunt err_code dut%0d got %0d want %0d", d, ec_a[d], exp_ec[d]); else n_pass++;
            if (busy_a[d] !== exp_busy[d]) $display("FAIL sync_hunt busy dut%0d got %b want %b", d, busy_a[d], exp_busy[d]); else n_pass++;
        end
    endtask

    task automatic test_checksum();
        int miss, extra;
        logic [7:0] good [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        seg_begin();
        foreach (good[i]) send(good[i], 0);
        idle(3);
        n_checks++;
        if (ec_a[0] !== 2'd0) $display("FAIL checksum_good err_code got %0d want 0", ec_a[0]); else n_pass++;
        foreach (good[i]) send((i == 5) ? 8'h0B : good[i], 0);
        idle(5);
        n_checks++;
        if (ec_a[0] !== 2'd1) $display("FAIL checksum_bad err_code got %0d want 1", ec_a[0]); else n_pass++;
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL checksum events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL checksum events_unexpected got %0d want 0", extra); else n_pass++;
        for (int d = 0; d < NDUT; d++) begin
            n_checks += 2;
            if (ec_a[d] !== exp_ec[d]) $display("FAIL checksum err_code dut%0d got %0d want %0d", d, ec_a[d], exp_ec[d]); else n_pass++;
            if (busy_a[d] !== exp_busy[d]) $display("FAIL checksum busy dut%0d got %b want %b", d, busy_a[d], exp_busy[d]); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int miss, extra;
        int t_last;
        bit seen;
        logic [7:0] good [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        seg_begin();
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        t_last = s_edge[2];
        idle(30);
        seen = 0;
        foreach (obs_q[j]) if (obs_q[j].d == 0 && obs_q[j].k == EV_ERR && obs_q[j].e == t_last + 20) seen = 1;
        n_checks++;
        if (seen !== 1'b1) $display("FAIL timeout_edge dut0 pkt_err at last+20 got %b want 1", seen); else n_pass++;
        foreach (good[i]) send(good[i], 0);
        idle(5);
        n_checks += 2;
        if (ec_a[0] !== 2'd2) $display("FAIL timeout_sticky dut0 err_code got %0d want 2", ec_a[0]); else n_pass++;
        if (ec_a[1] !== 2'd2) $display("FAIL timeout_sticky dut1 err_code got %0d want 2", ec_a[1]); else n_pass++;
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL timeout events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL timeout events_unexpected got %0d want 0", extra); else n_pass++;
        for (int d = 0; d < NDUT; d++) begin
            n_checks += 2;
            if (ec_a[d] !== exp_ec[d]) $display("FAIL timeout err_code dut%0d got %0d want %0d", d, ec_a[d], exp_ec[d]); else n_pass++;
            if (busy_a[d] !== exp_busy[d]) $display("FAIL timeout busy dut%0d got %b want %b", d, busy_a[d], exp_busy[d]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int miss, extra, n_upd, n_rdy;
        seg_begin();
        for (int i = 0; i < 110; i++) send(8'($urandom_range(0, 255)), 0);
        idle(5);
        n_upd = 0;
        n_rdy = 0;
        foreach (obs_q[j]) begin
            if (obs_q[j].d == 2 && obs_q[j].k == EV_UPD) n_upd++;
            if (obs_q[j].d == 2 && obs_q[j].k == EV_RDY) n_rdy++;
        end
        n_checks += 2;
        if (n_upd !== 110) $display("FAIL back_to_back dut2 update count got %0d want 110", n_upd); else n_pass++;
        if (n_rdy !== 2) $display("FAIL back_to_back dut2 pc_ready count got %0d want 2", n_rdy); else n_pass++;
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL back_to_back events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL back_to_back events_unexpected got %0d want 0", extra); else n_pass++;
        for (int d = 0; d < NDUT; d++) begin
            n_checks += 2;
            if (ec_a[d] !== exp_ec[d]) $display("FAIL back_to_back err_code dut%0d got %0d want %0d", d, ec_a[d], exp_ec[d]); else n_pass++;
            if (busy_a[d] !== exp_busy[d]) $display("FAIL back_to_back busy dut%0d got %b want %b", d, busy_a[d], exp_busy[d]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int miss, extra;
        logic [7:0] p1 [4] = '{8'hA5, 8'h01, 8'h02, 8'h03};
        logic [7:0] p2 [6] = '{8'hA5, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA};
        seg_begin();
        foreach (p1[i]) send(p1[i], 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({upd_a[d], rd_a[d], idx_a[d], pcr_a[d], err_a[d], ec_a[d], busy_a[d]} !== 22'd0)
                $display("FAIL reset_mid_outputs dut%0d got upd=%b rd=%02h idx=%0d busy=%b want all 0",
                         d, upd_a[d], rd_a[d], idx_a[d], busy_a[d]);
            else n_pass++;
        end
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL reset_mid_part1 events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL reset_mid_part1 events_unexpected got %0d want 0", extra); else n_pass++;
        idle(4);
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL reset_mid_silence strobes during reset got %0d want 0", obs_q.size()); else n_pass++;
        seg_begin();
        foreach (p2[i]) send(p2[i], 0);
        idle(6);
        seg_eval(miss, extra);
        n_checks += 3;
        if (miss !== 0) $display("FAIL reset_mid_part2 events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL reset_mid_part2 events_unexpected got %0d want 0", extra); else n_pass++;
        if (ec_a[0] !== 2'd0) $display("FAIL reset_mid_part2 dut0 err_code got %0d want 0", ec_a[0]); else n_pass++;
    endtask

    task automatic test_sync_data_collision();
        int miss, extra, n_err0;
        bit a5_seen;
        seg_begin();
        send(8'hA5, 0);
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 19);
        send(8'hAB, 19);
        idle(25);
        n_err0 = 0;
        a5_seen = 0;
        foreach (obs_q[j]) begin
            if (obs_q[j].d == 0 && obs_q[j].k == EV_ERR) n_err0++;
            if (obs_q[j].d == 0 && obs_q[j].k == EV_UPD && obs_q[j].ix == 0 && obs_q[j].dat == 8'hA5) a5_seen = 1;
        end
        n_checks += 3;
        if (n_err0 !== 0) $display("FAIL collision dut0 pkt_err count got %0d want 0", n_err0); else n_pass++;
        if (a5_seen !== 1'b1) $display("FAIL sync_as_data dut0 idx0=A5 strobe got %b want 1", a5_seen); else n_pass++;
        if (ec_a[0] !== 2'd0) $display("FAIL collision dut0 err_code got %0d want 0", ec_a[0]); else n_pass++;
        seg_eval(miss, extra);
        n_checks += 2;
        if (miss !== 0) $display("FAIL collision events_missing got %0d want 0", miss); else n_pass++;
        if (extra !== 0) $display("FAIL collision events_unexpected got %0d want 0", extra); else n_pass++;
    endtask

    task automatic test_random();
        int miss, extra;
        int gaps [8] = '{0, 0, 0, 1, 5, 19, 20, 21};
        for (int s = 0; s < 6; s++) begin
            seg_begin();
            for (int i = 0; i < 30; i++)
                send(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)), gaps[$urandom_range(0, 7)]);
            idle(25);
            seg_eval(miss, extra);
            n_checks += 2;
            if (miss !== 0) $display("FAIL random seg%0d events_missing got %0d want 0", s, miss); else n_pass++;
            if (extra !== 0) $display("FAIL random seg%0d events_unexpected got %0d want 0", s, extra); else n_pass++;
            for (int d = 0; d < NDUT; d++) begin
                n_checks += 2;
                if (ec_a[d] !== exp_ec[d]) $display("FAIL random seg%0d err_code dut%0d got %0d want %0d", s, d, ec_a[d], exp_ec[d]); else n_pass++;
                if (busy_a[d] !== exp_busy[d]) $display("FAIL random seg%0d busy dut%0d got %b want %b", s, d, busy_a[d], exp_busy[d]); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_hunt();
        test_checksum();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_sync_data_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ia_pkt.md
Name: ia_pkt

Overview:
- Parametrised packet assembler; next generation of the host-upload byte indexer.
- Sits between the UART receiver (rx_done_tick/rx_data_out) and the GPU register file.
- Takes a byte stream and hunts for an optional sync byte. It then emits PKT_LEN indexed payload bytes as one-cycle register-update strobes.
- Optionally checks a trailing mod-256 checksum. Aborts on inter-byte timeout and reports errors.

Parameters:
- PKT_LEN, 55: payload bytes per packet, range 2..256.
- IDX_W, $clog2(PKT_LEN): width of idx.
- SYNC_EN, 1: 1 = packet must start with SYNC_BYTE; 0 = first byte received is payload index 0.
- SYNC_BYTE, 8'hA5: header value; not forwarded.
- CSUM_EN, 1: 1 = one checksum byte follows the payload; 0 = no checksum.
- TIMEOUT_CYC, 50000: maximum idle cycles between bytes inside a packet; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  one-cycle strobe, byte_data valid
- byte_data  in  8  received byte
- update_reg  out  1  one-cycle strobe, read_data/idx valid
- read_data  out  8  payload byte
- idx  out  IDX_W  payload index, 0..PKT_LEN-1
- pc_ready  out  1  one-cycle strobe, packet complete and valid
- pkt_err  out  1  one-cycle strobe, packet aborted
- err_code  out  2  last error: 0 none, 1 checksum, 2 timeout
- busy  out  1  high while a packet is in progress

Behaviour:
- **Reset.** reset low forces, immediately: all outputs to 0, state IDLE, byte counter 0, checksum accumulator 0, timeout counter 0. Reset mid-packet discards the partial packet; no pc_ready or pkt_err is issued.
- **Byte acceptance.** byte_valid may be high on consecutive cycles, and every such byte is accepted. No byte is ever dropped in any state.
- **FSM states.** IDLE, PAYLOAD, CHECK.
- **IDLE.**
  - SYNC_EN=1: a byte equal to SYNC_BYTE moves the FSM to PAYLOAD. It clears the counter, accumulator and timeout. Other bytes are discarded silently, with no strobe.
  - SYNC_EN=0: any byte is treated as payload index 0, handled exactly as in PAYLOAD.
- **PAYLOAD.** Byte accepted at edge E:
  - At edge E: read_data <= byte, idx <= counter, update_reg <= 1 for exactly one cycle. accumulator <= accumulator + byte (mod 256). counter increments.
  - read_data and idx hold between strobes.
  - A SYNC_BYTE value inside the payload is ordinary data.
  - When the accepted byte is index PKT_LEN-1: with CSUM_EN=1, go to CHECK. With CSUM_EN=0, go to IDLE and assert pc_ready at edge E+1 for one cycle, one cycle after the last update_reg.
- **CHECK.** Checksum byte accepted at edge E; it is not forwarded and no update_reg is issued.
  - If the byte equals the accumulator: pc_ready <= 1 at edge E for one cycle.
  - Otherwise: pkt_err <= 1 for one cycle and err_code <= 1.
  - Either way, go to IDLE.
- **Timeout.**
  - In PAYLOAD or CHECK, the counter increments on every cycle without byte_valid and clears on every accepted byte.
  - At count TIMEOUT_CYC-1 with no byte_valid: pkt_err pulses at the next edge, err_code <= 2, FSM goes to IDLE. The error edge is TIMEOUT_CYC edges after the last accepted byte.
  - The counter is inactive in IDLE.
  - If a byte arrives on the expiry cycle, the byte wins and no error is raised.
- **Back-to-back packets.** A byte arriving the cycle after the final payload/checksum byte is processed in IDLE. A sync byte there can overlap the pc_ready pulse.
- **err_code.** Holds the last error until reset or the next error; it is not cleared by a good packet.
- **busy.** busy = (state != IDLE), registered with the state.
- **Mutual exclusion.** update_reg, pc_ready and pkt_err never assert together for the same packet, except that update_reg for a new packet may coincide with pc_ready of the previous one.

Decomposition:
- **ia_pkg** holds:
  - the state encoding (IDLE/PAYLOAD/CHECK);
  - the err_code constants (ERR_NONE=0, ERR_CSUM=1, ERR_TIMEOUT=2);
  - the default SYNC_BYTE.
- **ia_timeout** (one sub-module) is the inter-byte idle counter.
  - Inputs: clk, reset, enable, clear.
  - Parameter: TIMEOUT_CYC.
  - Output: a one-cycle expire pulse, held at 0 when TIMEOUT_CYC=0.
- The UART receiver stays outside; a top-level wrapper connects rx_done_tick to byte_valid.

Test Plan:
1. **Sync hunt.** PKT_LEN=4, CSUM_EN=0. Send 11, A5, 01, 02, 03, 04 -> 11 ignored; update_reg x4 with idx 0..3 and data 01..04; pc_ready one cycle after the 4th strobe; busy low after.
2. **Checksum.** PKT_LEN=4, CSUM_EN=1.
   - Send A5, 01, 02, 03, 04, 0A -> pc_ready, err_code 0.
   - Repeat with 0B as the last byte -> pkt_err, err_code=1, no pc_ready.
3. **Timeout.** TIMEOUT_CYC=20. Send A5, 01, 02, then silence -> pkt_err exactly 20 edges after 02 accepted, err_code=2. A following complete packet -> pc_ready; err_code stays 2.
4. **Full-rate stream.** Default PKT_LEN=55, byte_valid every cycle, SYNC_EN=0, CSUM_EN=0 -> 55 consecutive update_reg strobes, last idx=54, pc_ready next cycle. An immediately following second packet starts at idx 0 with no byte lost.
5. **Reset mid-packet.** Pull reset low after idx 2 -> all outputs 0 asynchronously, with no pc_ready or pkt_err. After release, the next packet starts at idx 0.
6. **Sync value as data, and expiry collision.** SYNC_EN=1, payload containing A5 -> forwarded as data at its idx. A byte arriving exactly on the timeout expiry cycle -> accepted, no pkt_err.
